// File: rtl/par_seri_if.sv
// par_seri_if
// Bus bundle for the parallel-in / serial-out shift register. It carries the
// parallel word, the load and shift controls, and the serial output bit.
// The clock and reset are not part of this bundle. They stay scalar ports on
// the design.
//
// Signals:
//   en  - shift enable, level-sampled on the rising clock edge
//   ld  - parallel load strobe, level-sampled on the rising clock edge
//   pi  - WIDTH-bit parallel data word
//   so  - serial data out, MSB first
//
// Modports:
//   master - the data source/sink side (drives en, ld, pi; reads so)
//   slave  - the shift register side (reads en, ld, pi; drives so)
interface par_seri_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             ld;
  logic [WIDTH-1:0] pi;
  logic             so;

  modport master (
    output en,
    output ld,
    output pi,
    input  so
  );

  modport slave (
    input  en,
    input  ld,
    input  pi,
    output so
  );
endinterface

// File: rtl/par_seri.sv
// par_seri
// Parallel-in, serial-out shift register. A WIDTH-bit word is captured on a
// load strobe. It is then shifted out MSB first, one bit per enabled clock.
// Vacated positions fill with zeros, so the output reads 0 once the word has
// been fully shifted out.
//
// Ports:
//   ck   - clock; all state changes on the rising edge
//   rst  - synchronous active-high reset; clears the shift register
//   bus  - par_seri_if slave modport (en, ld, pi in; so out)
//
// Parameters:
//   WIDTH - shift register width; must be at least 2
module par_seri #(
  parameter int WIDTH = 4
) (
  input logic        ck,
  input logic        rst,
  par_seri_if.slave  bus
);

  // Shift register. The name ps is kept stable so benches can probe it
  // hierarchically.
  logic [WIDTH-1:0] ps;

  // Priority: reset, then load, then shift, else hold.
  // A load beats a simultaneous shift, so a reload mid-sequence restarts
  // the word immediately and the new MSB is on so right after the edge.
  always_ff @(posedge ck) begin
    if (rst) begin
      ps <= '0;
    end else if (bus.ld) begin
      ps <= bus.pi;
    end else if (bus.en) begin
      ps <= {ps[WIDTH-2:0], 1'b0};
    end
  end

  // The output comes straight from the register MSB. This means so can only
  // change just after a rising edge. There is no path from pi, en or ld to so.
  assign bus.so = ps[WIDTH-1];

endmodule

// File: tb/tb_par_seri.sv
// tb_par_seri
// Self-checking bench for par_seri with WIDTH=4.
//
// A stimulus process drives inputs on the falling edge. For each cycle it
// pushes the expected post-edge state into a scoreboard queue. A separate
// monitor process samples the design shortly after every rising edge. It then
// pops the queue and compares the results.
//
// The directed scenarios push hand-derived constants. The randomized phase
// pushes values from an arithmetic reference model: a load sets the value to
// pi, and a shift doubles the value modulo 2**WIDTH. The serial bit is 1 when
// the value is at least 2**(WIDTH-1).
module tb_par_seri;
  localparam int WIDTH = 4;
  localparam int MODULUS = 1 << WIDTH;
  localparam int HALF = 1 << (WIDTH - 1);

  typedef struct {
    logic [WIDTH-1:0] ps;
    logic             so;
    string            name;
  } exp_t;

  logic ck;
  logic rst;

  par_seri_if #(.WIDTH(WIDTH)) bus ();

  par_seri #(.WIDTH(WIDTH)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb_q[$];
  int          total;
  int          bad;
  int unsigned model_val;
  logic        last_so;

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Generic comparison helper; every call counts as one comparison.
  task automatic check_value(input string name, input int actual, input int required);
    total++;
    if (actual != required) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Reference model update for one rising edge.
  task automatic model_step(input logic r, input logic l, input logic e,
                            input logic [WIDTH-1:0] p);
    if (r) model_val = 0;
    else if (l) model_val = p;
    else if (e) model_val = (model_val * 2) % MODULUS;
  endtask

  // Drive one cycle of inputs at the falling edge. Then push the expected
  // post-edge state. When use_model is set, the expected value comes from
  // the reference model. Otherwise it is exp_ps, and the model is re-aligned
  // to that value. The mid-cycle check confirms that changing the inputs does
  // not disturb so.
  task automatic apply_stimulus(input string name, input logic r, input logic l,
                                input logic e, input logic [WIDTH-1:0] p,
                                input bit use_model, input logic [WIDTH-1:0] exp_ps);
    exp_t item;
    @(negedge ck);
    rst    = r;
    bus.ld = l;
    bus.en = e;
    bus.pi = p;
    model_step(r, l, e, p);
    if (use_model) item.ps = model_val[WIDTH-1:0];
    else begin
      item.ps   = exp_ps;
      model_val = exp_ps;
    end
    item.so   = (int'(item.ps) >= HALF);
    item.name = name;
    sb_q.push_back(item);
    #1;
    if (last_so !== 1'bx) check_value({name, "_so_stable"}, int'(bus.so), int'(last_so));
    last_so = item.so;
  endtask

  // Monitor: sample just after each rising edge and compare with the scoreboard.
  initial begin : monitor
    exp_t item;
    forever begin
      @(posedge ck);
      #1;
      if (sb_q.size() > 0) begin
        item = sb_q.pop_front();
        check_value({item.name, "_ps"}, int'(dut.ps), int'(item.ps));
        check_value({item.name, "_so"}, int'(bus.so), int'(item.so));
      end
    end
  end

  initial begin : stimulus
    int wait_cycles;
    logic r, l, e;
    logic [WIDTH-1:0] p;
    total     = 0;
    bad       = 0;
    model_val = 0;
    last_so   = 1'bx;
    rst       = 1'b0;
    bus.ld    = 1'b0;
    bus.en    = 1'b0;
    bus.pi    = '0;

    // Reset wins over a simultaneous load.
    apply_stimulus("reset", 1, 1, 0, 4'hF, 0, 4'b0000);

    // Load 4'hD, then shift 5 times.
    apply_stimulus("load_d",   0, 1, 0, 4'hD, 0, 4'b1101);
    apply_stimulus("shift1",   0, 0, 1, 4'h0, 0, 4'b1010);
    apply_stimulus("shift2",   0, 0, 1, 4'h3, 0, 4'b0100);
    apply_stimulus("shift3",   0, 0, 1, 4'h7, 0, 4'b1000);
    apply_stimulus("shift4",   0, 0, 1, 4'hF, 0, 4'b0000);
    apply_stimulus("shift5",   0, 0, 1, 4'h5, 0, 4'b0000);

    // Hold for 3 cycles, then resume shifting.
    apply_stimulus("hold_ld",  0, 1, 0, 4'hD, 0, 4'b1101);
    apply_stimulus("hold1",    0, 0, 0, 4'h2, 0, 4'b1101);
    apply_stimulus("hold2",    0, 0, 0, 4'hA, 0, 4'b1101);
    apply_stimulus("hold3",    0, 0, 0, 4'h0, 0, 4'b1101);
    apply_stimulus("resume",   0, 0, 1, 4'h0, 0, 4'b1010);

    // A load beats a simultaneous shift.
    apply_stimulus("prio_ld",  0, 1, 0, 4'hD, 0, 4'b1101);
    apply_stimulus("prio_sh",  0, 0, 1, 4'h0, 0, 4'b1010);
    apply_stimulus("prio_both",0, 1, 1, 4'h6, 0, 4'b0110);
    apply_stimulus("prio_next",0, 0, 1, 4'h0, 0, 4'b1100);

    // Reset in the middle of a shift sequence.
    apply_stimulus("rm_ld",    0, 1, 0, 4'hF, 0, 4'b1111);
    apply_stimulus("rm_sh1",   0, 0, 1, 4'h0, 0, 4'b1110);
    apply_stimulus("rm_sh2",   0, 0, 1, 4'h0, 0, 4'b1100);
    apply_stimulus("rm_rst",   1, 0, 1, 4'h9, 0, 4'b0000);
    apply_stimulus("rm_after1",0, 0, 1, 4'h0, 0, 4'b0000);
    apply_stimulus("rm_after2",0, 0, 1, 4'h0, 0, 4'b0000);

    // Reload in the middle of a shift sequence.
    apply_stimulus("rl_ld9",   0, 1, 0, 4'h9, 0, 4'b1001);
    apply_stimulus("rl_sh",    0, 0, 1, 4'h0, 0, 4'b0010);
    apply_stimulus("rl_lda",   0, 1, 0, 4'hA, 0, 4'b1010);
    apply_stimulus("rl_sh1",   0, 0, 1, 4'h0, 0, 4'b0100);
    apply_stimulus("rl_sh2",   0, 0, 1, 4'h0, 0, 4'b1000);
    apply_stimulus("rl_sh3",   0, 0, 1, 4'h0, 0, 4'b0000);
    apply_stimulus("rl_sh4",   0, 0, 1, 4'h0, 0, 4'b0000);

    // Randomized phase checked against the reference model.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 5) == 0);
      e = ($urandom_range(0, 3) != 0);
      p = WIDTH'($urandom);
      apply_stimulus("rand", r, l, e, p, 1, '0);
    end

    // Let the monitor drain the scoreboard within a bounded number of cycles.
    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 20) begin
      @(posedge ck);
      #2;
      wait_cycles++;
    end
    check_value("drain_timeout", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
